// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and, later, the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    // Start bit + data bits + stop bit.
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick in the last cycle of each period.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(1);
        end
    end

    assign tick = (count_q == CntMax) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 transmitter that pops bytes from a FIFO read port and serializes them onto the TX pin.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_enable,
    input  logic       in_fifo_empty,
    output logic       out_fifo_read,
    input  logic [7:0] in_fifo_data,
    output logic       out_tx,
    output logic       out_busy,
    output logic       out_byte_done
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       tx_q, tx_d;
    logic       baud_clear;
    logic       baud_tick;
    logic       fifo_read;
    logic       byte_done;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        fifo_read  = 1'b0;
        byte_done  = 1'b0;
        baud_clear = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                baud_clear = 1'b1;
                if (in_enable && !in_fifo_empty) begin
                    fifo_read = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                baud_clear = 1'b1;
                shift_d    = in_fifo_data;
                bit_idx_d  = '0;
                state_d    = START;
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LastBit) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    byte_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line register is loaded with the level of the upcoming state, so out_tx
        // changes exactly on state boundaries.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    // Status strobes are masked during reset so no pop or completion leaks out of that cycle.
    assign out_fifo_read = fifo_read && !rst;
    assign out_byte_done = byte_done && !rst;
    assign out_busy      = (state_q != IDLE) && !rst;
    assign out_tx        = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx against a cycle-indexed frame model with a queue-based FIFO.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_enable;
    logic       in_fifo_empty;
    logic       out_fifo_read;
    logic [7:0] in_fifo_data;
    logic       out_tx;
    logic       out_busy;
    logic       out_byte_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_enable    (in_enable),
        .in_fifo_empty(in_fifo_empty),
        .out_fifo_read(out_fifo_read),
        .in_fifo_data (in_fifo_data),
        .out_tx       (out_tx),
        .out_busy     (out_busy),
        .out_byte_done(out_byte_done)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_reads_dut = 0;
    int         n_reads_exp = 0;
    logic [7:0] fq[$];
    bit         force_empty = 1'b0;
    bit         active = 1'b0;
    int         t_rd = 0;
    logic [7:0] fbyte = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Line level: start bit, 8 data bits LSB first, stop bit, each CPB cycles from t_rd+2.
    function automatic logic exp_line(input int c);
        int slot;
        if (!active || c < t_rd + 2 || c > t_rd + 1 + FRAME) return 1'b1;
        slot = (c - (t_rd + 2)) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return fbyte[slot-1];
    endfunction

    function automatic bit in_frame(input int c);
        return active && c <= t_rd + 1 + FRAME;
    endfunction

    task automatic update_empty();
        in_fifo_empty = force_empty || (fq.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        update_empty();
    endtask

    task automatic run_cycle();
        logic e_read;
        logic e_busy;
        logic e_done;
        bit   pop;
        @(negedge clk);
        e_read = !rst && in_enable && !in_fifo_empty && !in_frame(cyc);
        e_busy = !rst && in_frame(cyc) && cyc >= t_rd + 1;
        e_done = !rst && active && cyc == t_rd + 1 + FRAME;
        check_eq("tx", out_tx, exp_line(cyc));
        check_eq("busy", out_busy, e_busy);
        check_eq("byte_done", out_byte_done, e_done);
        check_eq("fifo_read", out_fifo_read, e_read);
        if (out_fifo_read === 1'b1) n_reads_dut++;
        pop = 1'b0;
        if (rst) begin
            active = 1'b0;
        end else if (e_read) begin
            active = 1'b1;
            t_rd   = cyc;
            fbyte  = fq[0];
            pop    = 1'b1;
            n_reads_exp++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop) in_fifo_data = fq.pop_front();
        else     in_fifo_data = 8'($urandom);
        update_empty();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic wait_frame_offset(input int offset, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (active && cyc == t_rd + offset) return;
            run_cycle();
        end
        check_eq(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        in_enable    = 1'b1;
        in_fifo_data = 8'h00;
        push(8'hA5);

        // Reset held with a readable FIFO, then a single 0xA5 frame.
        run_n(3);
        rst = 1'b0;
        run_n(50);
        check_eq("reads_after_a5", n_reads_dut, 1);

        // Back-to-back 0x00 then 0xFF.
        push(8'h00);
        push(8'hFF);
        run_n(100);
        check_eq("reads_after_b2b", n_reads_dut, 3);

        // Empty flag, then disabled enable, both block reads.
        force_empty = 1'b1;
        push(8'h3C);
        run_n(50);
        check_eq("reads_while_empty", n_reads_dut, 3);
        force_empty = 1'b0;
        in_enable   = 1'b0;
        update_empty();
        run_n(50);
        check_eq("reads_while_disabled", n_reads_dut, 3);

        // Enable dropped during data bit 3; 0x5A must stay in the FIFO.
        push(8'h5A);
        in_enable = 1'b1;
        wait_frame_offset(2 + 4 * CPB + 1, "wait_bit3");
        in_enable = 1'b0;
        run_n(60);
        check_eq("reads_after_enable_drop", n_reads_dut, 4);
        check_eq("fifo_left_after_drop", fq.size(), 1);

        // Reset during data bit 5, then a clean frame for 0xC3.
        push(8'hC3);
        in_enable = 1'b1;
        wait_frame_offset(2 + 6 * CPB + 1, "wait_bit5");
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_n(60);
        check_eq("reads_after_reset", n_reads_dut, 6);

        // Random traffic with occasional gating and resets.
        for (int i = 0; i < 1500; i++) begin
            in_enable   = ($urandom_range(0, 9) != 0);
            force_empty = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0 && fq.size() < 6) fq.push_back(8'($urandom));
            update_empty();
            run_cycle();
        end
        rst         = 1'b0;
        in_enable   = 1'b1;
        force_empty = 1'b0;
        update_empty();
        run_n(400);
        check_eq("fifo_drained", fq.size(), 0);
        check_eq("reads_total", n_reads_dut, n_reads_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the byte FIFO from its read side and sends each byte as an 8N1 asynchronous frame: one start bit, 8 data bits LSB first, one stop bit. It sits between the byte FIFO's read port and the off-chip TX pin. It issues one FIFO read pulse per byte, captures the byte returned on the following cycle, and serializes it at a fixed clocks-per-bit rate.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_enable  input  1  permits starting a new frame; a frame in progress always completes.
- in_fifo_empty  input  1  FIFO empty flag; a read is issued only while this is 0.
- out_fifo_read  output  1  single-cycle FIFO pop request.
- in_fifo_data  input  8  FIFO read data; valid in the cycle after out_fifo_read.
- out_tx  output  1  serial line; idles high.
- out_busy  output  1  high in every state except IDLE.
- out_byte_done  output  1  single-cycle pulse in the last cycle of the stop bit.

## Operation
- States:
  - IDLE: out_tx=1. If in_enable & ~in_fifo_empty, assert out_fifo_read for this cycle and go to FETCH.
  - FETCH: one cycle. Latch in_fifo_data into an 8-bit shift register, clear the baud counter, go to START.
  - START: out_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: out_tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After the cycle with bit index 7 completes, go to STOP.
  - STOP: out_tx=1 for CLKS_PER_BIT cycles. Pulse out_byte_done in the final cycle, then go to IDLE.
- Read rule: out_fifo_read is asserted only in IDLE, only when in_fifo_empty=0, and at most once per frame. The block never pops a FIFO that reports empty.
- Arithmetic and widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps to 0 at the bit boundary.
  - Bit index is 3 bits.
- out_tx is driven from a register, so it is glitch-free.
- Boundary conditions:
  - in_enable falls mid-frame: the frame finishes normally and no new read is issued.
  - in_fifo_empty rises during a frame: no effect on the current frame.
  - Back-to-back bytes: after STOP, IDLE re-arbitrates immediately.
  - in_fifo_data outside FETCH is ignored.
- Reset mid-frame: the next cycle is IDLE, out_tx=1, and the partially sent byte is lost. No read is issued in the reset cycle.

## Timing
- Reset values: out_tx=1, out_fifo_read=0, out_busy=0, out_byte_done=0, state=IDLE, counters 0.
- Read at cycle t (IDLE) gives:
  - capture at t+1 (FETCH);
  - start bit over cycles t+2 .. t+1+CLKS_PER_BIT;
  - data bit k over cycles t+2+(k+1)*CLKS_PER_BIT .. t+1+(k+2)*CLKS_PER_BIT;
  - stop bit ending at cycle t+1+10*CLKS_PER_BIT, where out_byte_done is high.
- Frame length on the line is exactly 10*CLKS_PER_BIT cycles.
- Inter-frame gap with a non-empty FIFO is 2 idle-high cycles (IDLE, FETCH). Sustained throughput is 1 byte per 10*CLKS_PER_BIT+2 cycles.
- out_busy is high from t+1 through the last stop cycle.

## Structure
- Shared package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, FETCH, START, DATA, STOP};
  - localparam DATA_BITS=8.
  - The frame length constant (DATA_BITS+2) is shared with the future receiver.
- One sub-module is natural: uart_baud_counter(clk, rst, clear, tick), parameterized by CLKS_PER_BIT. It pulses tick in the last cycle of each bit period and is reused by the receiver.
- Top level contains the FSM, shift register, and bit index.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold rst 3 cycles with in_fifo_empty=0 and in_enable=1 -> out_tx=1, out_fifo_read=0, out_busy=0 throughout reset.
- Single byte 0xA5: read at cycle t -> out_tx low t+2..t+5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high t+38..t+41, out_byte_done at t+41, exactly one read pulse.
- Back-to-back 0x00 then 0xFF: FIFO non-empty for 2 bytes -> second read at the cycle after the first out_byte_done, 2-cycle high gap, 2 reads total, line returns high.
- Empty/enable gating: in_fifo_empty=1 for 50 cycles, then in_enable=0 with a non-empty FIFO -> zero read pulses, out_tx constantly 1.
- in_enable dropped mid-frame (during data bit 3) -> frame completes with correct bits and no further read.
- rst asserted during data bit 5 -> out_tx=1 and out_busy=0 the next cycle; after release, the next byte's frame is sent cleanly from a start bit.
